// File: rtl/clause_tbl_pkg.sv
// -----------------------------------------------------------------------------
// clause_tbl_pkg
// Shared types and defaults for the clause table arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default clause table geometry (depth = 2**ADDR_W)
//   state_e                 : sequencer states (INIT zero sweep, RUN arbitration)
//   owner_e                 : tag of the port owed read data next cycle
// -----------------------------------------------------------------------------
package clause_tbl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_BCP  = 2'd2
  } owner_e;

endpackage

// File: rtl/clause_table_arb_if.sv
// -----------------------------------------------------------------------------
// clause_table_arb_if
// Requester-side bus of the clause table arbiter: host loader (read/write)
// and BCP engine (read-only).
//   master : requester view (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave  : arbiter view
// -----------------------------------------------------------------------------
interface clause_table_arb_if
  import clause_tbl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              bcp_req;
  logic [ADDR_W-1:0] bcp_addr;
  logic              bcp_gnt;
  logic              bcp_rvalid;
  logic [DATA_W-1:0] bcp_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata, bcp_req, bcp_addr,
    input  host_gnt, host_rvalid, host_rdata, bcp_gnt, bcp_rvalid, bcp_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, bcp_req, bcp_addr,
    output host_gnt, host_rvalid, host_rdata, bcp_gnt, bcp_rvalid, bcp_rdata
  );

endinterface

// File: rtl/clause_table_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. Grants are combinational from the requests
// and the priority pointer; the pointer moves to the non-granted port after
// every grant, so sustained contention alternates strictly.
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : arbitration enabled (low forces both grants off)
//   req_h, req_b : host / BCP requests
//   gnt_h, gnt_b : host / BCP grants (at most one high)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_h,
  input  logic req_b,
  output logic gnt_h,
  output logic gnt_b
);

  // Priority pointer: 0 = host wins a tie, 1 = BCP wins a tie.
  logic prio_q;

  always_comb begin
    gnt_h = en && req_h && (!req_b || !prio_q);
    gnt_b = en && req_b && (!req_h ||  prio_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b1;
    end else if (gnt_h) begin
      prio_q <= 1'b1;
    end else if (gnt_b) begin
      prio_q <= 1'b0;
    end
  end

endmodule

// File: rtl/clause_table_arb.sv
// -----------------------------------------------------------------------------
// clause_table_arb
// Arbiter and init sequencer for the single-port clause table RAM. Shares the
// table between the host loader and the BCP engine with one access per cycle
// (round-robin on contention) and returns read data one cycle after grant,
// tagged to the port that issued the read.
//
// Build option: define CLAUSE_TBL_INIT_EN to compile in the post-reset sweep
// that writes zero to every entry before any requester is served. Without it,
// reset goes straight to RUN and init_busy is tied low.
//
// Ports
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : host/BCP request bus (slave modport)
//   tbl_en/we   : RAM enable / write enable
//   tbl_addr    : RAM address
//   tbl_di      : RAM write data
//   tbl_dout    : RAM read data, valid the cycle after an enabled access
//   init_busy   : zero sweep in progress
// -----------------------------------------------------------------------------
module clause_table_arb
  import clause_tbl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  clause_table_arb_if.slave   bus,
  output logic                tbl_en,
  output logic                tbl_we,
  output logic [ADDR_W-1:0]   tbl_addr,
  output logic [DATA_W-1:0]   tbl_di,
  input  logic [DATA_W-1:0]   tbl_dout,
  output logic                init_busy
);

  state_e            state_q, state_d;
  owner_e            rd_own_q;
  logic              run;
  logic              gnt_h, gnt_b;
  logic [DATA_W-1:0] host_hold_q, bcp_hold_q;

`ifdef CLAUSE_TBL_INIT_EN
  logic [ADDR_W-1:0] init_cnt_q;
  localparam state_e RESET_STATE = INIT;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  // Arbitration is only live in RUN and never while reset is asserted.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .req_h (bus.host_req),
    .req_b (bus.bcp_req),
    .gnt_h (gnt_h),
    .gnt_b (gnt_b)
  );

  assign bus.host_gnt = gnt_h;
  assign bus.bcp_gnt  = gnt_b;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

`ifdef CLAUSE_TBL_INIT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)               init_cnt_q <= '0;
    else if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
  end
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    init_busy = 1'b0;
    run       = 1'b0;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_di    = '0;
    case (state_q)
`ifdef CLAUSE_TBL_INIT_EN
      INIT: begin
        init_busy = 1'b1;
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = init_cnt_q;
        if (init_cnt_q == '1) state_d = RUN;
      end
`endif
      default: begin
        run = rst_n;
        if (gnt_h) begin
          tbl_en   = 1'b1;
          tbl_we   = bus.host_we;
          tbl_addr = bus.host_addr;
          tbl_di   = bus.host_wdata;
        end else if (gnt_b) begin
          tbl_en   = 1'b1;
          tbl_addr = bus.bcp_addr;
        end
      end
    endcase
  end

  // Owner tag for the data the RAM presents next cycle; writes earn no tag.
  // The hold registers keep the last delivered word while rvalid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_own_q    <= OWN_NONE;
      host_hold_q <= '0;
      bcp_hold_q  <= '0;
    end else begin
      if (gnt_h && !bus.host_we) rd_own_q <= OWN_HOST;
      else if (gnt_b)            rd_own_q <= OWN_BCP;
      else                       rd_own_q <= OWN_NONE;
      if (bus.host_rvalid) host_hold_q <= tbl_dout;
      if (bus.bcp_rvalid)  bcp_hold_q  <= tbl_dout;
    end
  end

  // rvalid is masked by rst_n so a read in flight when reset hits is dropped.
  always_comb begin
    bus.host_rvalid = rst_n && (rd_own_q == OWN_HOST);
    bus.bcp_rvalid  = rst_n && (rd_own_q == OWN_BCP);
    bus.host_rdata  = bus.host_rvalid ? tbl_dout : host_hold_q;
    bus.bcp_rdata   = bus.bcp_rvalid  ? tbl_dout : bcp_hold_q;
  end

endmodule

// File: tb/tb_clause_table_arb.sv
module tb_clause_table_arb;
  import clause_tbl_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int NVEC  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tbl_en, tbl_we, init_busy;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_di;
  logic [DW-1:0] tbl_dout;

  int n_vec  = 0;
  int n_miss = 0;

  clause_table_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  clause_table_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .tbl_en    (tbl_en),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_di    (tbl_di),
    .tbl_dout  (tbl_dout),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered read, one-cycle latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_di;
      tbl_dout <= mem[tbl_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a read grant pushes the expected data; it must come back
  // exactly one cycle later on the owner's port.
  initial begin : scoreboard
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_known [DEPTH];
    logic [DW:0]   hq[$], bq[$];
    logic [DW:0]   e;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hq.delete();
        bq.delete();
      end else begin
        check("host_rvalid", bus.host_rvalid, hq.size() != 0);
        if (hq.size() != 0) begin
          e = hq.pop_front();
          if (bus.host_rvalid && e[DW]) check("host_rdata", bus.host_rdata, e[DW-1:0]);
        end
        check("bcp_rvalid", bus.bcp_rvalid, bq.size() != 0);
        if (bq.size() != 0) begin
          e = bq.pop_front();
          if (bus.bcp_rvalid && e[DW]) check("bcp_rdata", bus.bcp_rdata, e[DW-1:0]);
        end
        if (bus.host_gnt) begin
          if (bus.host_we) begin
            ref_mem[bus.host_addr]   = bus.host_wdata;
            ref_known[bus.host_addr] = 1'b1;
          end else begin
            hq.push_back({ref_known[bus.host_addr], ref_mem[bus.host_addr]});
          end
        end
        if (bus.bcp_gnt) bq.push_back({ref_known[bus.bcp_addr], ref_mem[bus.bcp_addr]});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic          hreq;
    logic          hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic          breq;
    logic [AW-1:0] baddr;
    logic          eh;
    logic          eb;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input bit hreq, input bit hwe, input bit [AW-1:0] haddr,
                              input bit [DW-1:0] hwd, input bit breq, input bit [AW-1:0] baddr,
                              input bit eh, input bit eb);
    vec_t v;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.breq = breq; v.baddr = baddr; v.eh = eh; v.eb = eb;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hreq, input logic hwe, input logic [AW-1:0] haddr,
                       input logic [DW-1:0] hwd, input logic breq, input logic [AW-1:0] baddr);
    bus.host_req = hreq; bus.host_we = hwe; bus.host_addr = haddr; bus.host_wdata = hwd;
    bus.bcp_req = breq; bus.bcp_addr = baddr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst host_gnt", bus.host_gnt, 1'b0);
    check("rst bcp_gnt", bus.bcp_gnt, 1'b0);
    check("rst host_rvalid", bus.host_rvalid, 1'b0);
    check("rst bcp_rvalid", bus.bcp_rvalid, 1'b0);
    check("rst host_rdata", bus.host_rdata, '0);
    check("rst bcp_rdata", bus.bcp_rdata, '0);
`ifdef CLAUSE_TBL_INIT_EN
    check("rst init_busy", init_busy, 1'b1);
`else
    check("rst init_busy", init_busy, 1'b0);
`endif
    next_cycle();
    rst_n = 1'b1;
  endtask

`ifdef CLAUSE_TBL_INIT_EN
  // Checks the zero sweep cycle by cycle; abort_at >= 0 pulses reset for one
  // cycle when the sweep reaches that address and returns.
  task automatic sweep(input int abort_at);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("init busy", init_busy, 1'b1);
      check("init en_we", {tbl_en, tbl_we}, 2'b11);
      check("init di", tbl_di, '0);
      check("init addr", tbl_addr, i);
      check("init gnts", {bus.host_gnt, bus.bcp_gnt}, 2'b00);
      next_cycle();
      if (i + 1 == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst addr", tbl_addr, abort_at);
        check("midrst gnts", {bus.host_gnt, bus.bcp_gnt}, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        return;
      end
    end
  endtask
`endif

  task automatic reset_and_init();
    idle();
    do_reset();
`ifdef CLAUSE_TBL_INIT_EN
    sweep(-1);
`endif
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 1'b1, 5'd5, 4'hA, 1'b0, 5'd0, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 5'd5, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 1'b1, 5'd3, 4'h7, 1'b0, 5'd0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 5'd3, 4'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 5; i <= 10; i++)
      vecs[i] = mk(1'b1, 1'b0, 5'd5, 4'h0, 1'b1, 5'd3, (i % 2) == 0, (i % 2) == 1);
    vecs[11] = mk(1'b1, 1'b1, 5'd9, 4'hC, 1'b1, 5'd5, 1'b0, 1'b1);
    vecs[12] = mk(1'b1, 1'b1, 5'd9, 4'hC, 1'b0, 5'd0, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 5'd9, 1'b0, 1'b1);
    vecs[14] = mk(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);

    idle();
`ifdef CLAUSE_TBL_INIT_EN
    // Both ports request throughout the sweep; BCP wins first afterwards.
    drive(1'b1, 1'b0, 5'd0, 4'h0, 1'b1, 5'd0);
    do_reset();
    sweep(-1);
    @(negedge clk);
    check("post-init busy", init_busy, 1'b0);
    check("post-init gnts", {bus.host_gnt, bus.bcp_gnt}, 2'b01);
    next_cycle();
    idle();
    // Reset at address 17 restarts the sweep with a full 32 writes.
    do_reset();
    sweep(17);
    sweep(-1);
    @(negedge clk);
    check("restart busy", init_busy, 1'b0);
    next_cycle();
`else
    // Without the sweep, a request is served in the first cycle after reset.
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 4'h0, 1'b0, 5'd0);
    @(negedge clk);
    check("first host_gnt", bus.host_gnt, 1'b1);
    check("first init_busy", init_busy, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("first init_busy2", init_busy, 1'b0);
    next_cycle();
`endif

    reset_and_init();
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd, vecs[i].breq, vecs[i].baddr);
      @(negedge clk);
      check($sformatf("v%0d host_gnt", i), bus.host_gnt, vecs[i].eh);
      check($sformatf("v%0d bcp_gnt", i), bus.bcp_gnt, vecs[i].eb);
      check($sformatf("v%0d tbl_en", i), tbl_en, vecs[i].eh | vecs[i].eb);
      check($sformatf("v%0d tbl_we", i), tbl_we, vecs[i].eh & vecs[i].hwe);
      if (vecs[i].eh)      check($sformatf("v%0d tbl_addr", i), tbl_addr, vecs[i].haddr);
      else if (vecs[i].eb) check($sformatf("v%0d tbl_addr", i), tbl_addr, vecs[i].baddr);
      next_cycle();
    end

    // rdata holds the last delivered word once rvalid drops.
    @(negedge clk);
    check("hold host_rdata", bus.host_rdata, 4'hA);
    check("hold bcp_rdata", bus.bcp_rdata, 4'hC);
    next_cycle();

    // Reset in the cycle after a read grant drops the pending rvalid.
    drive(1'b1, 1'b0, 5'd3, 4'h0, 1'b0, 5'd0);
    @(negedge clk);
    check("midread host_gnt", bus.host_gnt, 1'b1);
    next_cycle();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("midread rvalid", bus.host_rvalid, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("midread rvalid2", {bus.host_rvalid, bus.bcp_rvalid}, 2'b00);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clause_table_arb.md
# clause_table_arb

Two-port arbiter and init sequencer for the single-port clause table RAM in hardware BCP. It shares the table between the host loader (read/write) and the BCP engine (read-only), granting one access per cycle with round-robin fairness. Read data returns one cycle after grant and is tagged back to the owner. An optional post-reset sweep zeroes every entry before any requester is served.

## Interface
- ADDR_W, 5, clause table address width; depth = 2**ADDR_W
- DATA_W, 4, clause table entry width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- host_req  in  1  host access request; hold with stable fields until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host_rdata valid (reads only)
- host_rdata  out  DATA_W  host read data
- bcp_req  in  1  BCP read request; hold until bcp_gnt
- bcp_addr  in  ADDR_W  BCP read address
- bcp_gnt  out  1  BCP read performed this cycle
- bcp_rvalid  out  1  bcp_rdata valid
- bcp_rdata  out  DATA_W  BCP read data
- tbl_en, tbl_we  out  1 each  RAM enable / write enable
- tbl_addr  out  ADDR_W  RAM address
- tbl_di  out  DATA_W  RAM write data
- tbl_dout  in  DATA_W  RAM read data (valid the cycle after an enabled access)
- init_busy  out  1  init sweep in progress

## Operation
- States: INIT, RUN. Reset enters INIT (macro defined) or RUN (undefined).
- INIT: tbl_en=1, tbl_we=1, tbl_di=0, tbl_addr=init_cnt; init_cnt increments 0..2**ADDR_W-1; after the last address, move to RUN. Both gnt low throughout.
- RUN: gnts combinational from req and priority pointer prio (0 = host, 1 = BCP).
  - Single requester: granted the same cycle.
  - Both: prio winner granted; loser stays pending.
  - prio updates on every grant to point at the non-granted port; reset value 1 (BCP first).
- Granted access drives tbl_en=1, tbl_we=host_we for host (0 for BCP), tbl_addr/tbl_di from the winner. No grant: tbl_en=0.
- Read return: registered owner tag rd_own (none/host/BCP); the next cycle, the owner's rvalid=1 and rdata=tbl_dout. Host writes raise no rvalid.
- rdata holds its last value when rvalid=0.

## Timing
- Reset values: host_gnt=0, bcp_gnt=0, host_rvalid=0, bcp_rvalid=0, host_rdata=0, bcp_rdata=0, init_busy=1 (macro) / 0, init_cnt=0, prio=1, rd_own=none. gnts forced 0 while rst_n=0.
- Grant latency 0 cycles; read latency 1 cycle after gnt; throughput 1 access/cycle.
- INIT lasts exactly 2**ADDR_W cycles (32 by default); first grant possible in the cycle after the last INIT write.
- Reset mid-INIT restarts the sweep at address 0. Reset mid-read: pending rvalid dropped.
- Host write then BCP read of the same address on the next cycle returns the new data.
- Back-to-back contention alternates strictly: H,B,H,B…; neither port waits more than 1 cycle.

## Configuration
- CLAUSE_TBL_INIT_EN defined: INIT state, init_cnt and zero sweep compiled in.
- Undefined: reset goes directly to RUN, init_busy tied 0, table contents undefined until host writes.

## Structure
- Package clause_tbl_pkg: ADDR_W/DATA_W defaults, state enum (INIT, RUN), owner enum (OWN_NONE, OWN_HOST, OWN_BCP).
- One natural sub-module: rr_arb2 (two-input round-robin arbiter, combinational gnt + prio register). Clause table RAM is instantiated by the parent, not here.

## Test plan
- Reset with macro: init_busy high 32 cycles, tbl_we=1, tbl_di=0, addresses 0..31; both reqs held high receive no gnt until cycle 33.
- Host write addr 5 = 4'hA, next cycle BCP read addr 5 -> bcp_gnt same cycle, bcp_rvalid one cycle later with bcp_rdata=4'hA.
- Both req held 6 cycles, post-reset -> grants B,H,B,H,B,H; rvalid tags match.
- Host read addr 3 after write 4'h7 -> host_rvalid=1, host_rdata=4'h7, bcp_rvalid=0.
- rst_n low at init_cnt=17 for one cycle -> sweep restarts at 0, full 32 cycles again.
- Macro undefined: first cycle after reset, host_req read addr 0 -> host_gnt=1 immediately, init_busy=0 throughout.
